pwm_controller: RTL and testbench
=================================

PWM_CONTROLLER -- requirements
Module: pwm_controller

Interface
REQ-001 The block SHALL have one parameter: PRESCALE, default 3, the clk-to-tick divide minus one, used only when PWM_PRESCALE_EN is defined.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Port: clk  input  1  block clock; all logic on the rising edge.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: en_reg_out_7_0  input  8  output-enable bits for channels 7..0.
REQ-006 Port: en_reg_out_15_8  input  8  output-enable bits for channels 15..8.
REQ-007 Port: en_reg_pwm_7_0  input  8  PWM-mode bits for channels 7..0.
REQ-008 Port: en_reg_pwm_15_8  input  8  PWM-mode bits for channels 15..8.
REQ-009 Port: pwm_duty_cycle  input  8  shared duty value, 0..255.
REQ-010 Port: cfg_update  input  1  single-cycle pulse; new register values are valid.
REQ-011 Port: cfg_pending  output  1  update requested but not yet applied.
REQ-012 Port: period_start  output  1  single-cycle pulse at each period wrap.
REQ-013 Port: pwm_out  output  16  channel outputs.

Function
REQ-014 The tick generator SHALL count 0..PRESCALE and assert tick in the cycle the count equals PRESCALE, then return to 0.
REQ-015 The period counter cnt (8 bit) SHALL advance by 1 on each tick and wrap from 255 to 0.
REQ-016 A boundary SHALL be defined as tick AND cnt==255.
REQ-017 period_start SHALL be registered and pulse high for exactly one clk, in the cycle after each boundary.
REQ-018 The update FSM SHALL have two states: IDLE (cfg_pending=0) and PENDING (cfg_pending=1).
REQ-019 In IDLE, cfg_update SHALL move the FSM to PENDING.
REQ-020 In PENDING, a boundary SHALL load all five inputs into shadow registers and return the FSM to IDLE.
REQ-021 Inputs SHALL be sampled at the boundary, not at cfg_update; repeated cfg_update pulses while PENDING have no further effect.
REQ-022 If cfg_update coincides with a boundary in IDLE, the shadows SHALL load in that cycle and the FSM SHALL stay IDLE.
REQ-023 If cfg_update coincides with a boundary in PENDING, the shadows SHALL load in that cycle and the FSM SHALL return to IDLE.
REQ-024 pwm_high SHALL be 1 when duty_sh==255, otherwise (cnt < duty_sh): duty 0 gives always low, duty 255 gives always high.
REQ-025 For each channel i, pwm_out[i] SHALL be registered as: en_out_sh[i]=0 gives 0; en_out_sh[i]=1 and en_pwm_sh[i]=0 gives 1; both set gives pwm_high.
REQ-026 pwm_out SHALL lag cnt and the shadow registers by exactly one clk.
REQ-027 pwm_out SHALL be glitch-free: it changes only on clk edges, and shadow changes never occur mid-period.

Reset
REQ-028 While rst is high, the prescaler, cnt, all shadow registers, pwm_out, cfg_pending and period_start SHALL be 0.
REQ-029 Reset asserted mid-period SHALL force pwm_out to 0 immediately and discard any pending update.
REQ-030 After rst deasserts, cnt SHALL restart at 0 and the first tick SHALL occur PRESCALE+1 clks later.

Configuration
REQ-031 With PWM_PRESCALE_EN defined, tick SHALL follow REQ-014, giving a period of 256*(PRESCALE+1) clks.
REQ-032 Without PWM_PRESCALE_EN, tick SHALL be constantly 1, no prescaler register SHALL exist, PRESCALE SHALL be ignored, and the period SHALL be 256 clks.

Verification
REQ-033 Reset scenario: assert rst mid-run with pwm_out=16'hFFFF -> pwm_out=0, cfg_pending=0, period_start=0 while rst is high.
REQ-034 Static-on scenario: en_reg_out_7_0=8'h01, en_reg_pwm_7_0=0, pulse cfg_update -> cfg_pending=1 until boundary; then pwm_out=16'h0001 steady.
REQ-035 50% duty scenario: all enables 8'hFF, duty 8'h80, macro off -> every channel high 128 clks, low 128 clks; period_start every 256 clks.
REQ-036 Duty extremes scenario: duty 8'h00 -> pwm_out stays 0; duty 8'hFF -> pwm_out stays 16'hFFFF across wraps.
REQ-037 Deferred update scenario: at cnt=10 with duty 8'h40, set duty 8'hC0 and pulse cfg_update -> old waveform completes; new duty applies from the next period; cfg_pending clears at the boundary.
REQ-038 Prescale scenario: PWM_PRESCALE_EN defined, PRESCALE=3, duty 8'h80 -> high 512 clks, low 512 clks; period_start every 1024 clks.

Source files
------------

// File: rtl/pwm_controller.sv
// pwm_controller: 16-channel PWM whose configuration is latched into shadow registers only at period wraps.
// Optional prescaler is enabled by defining PWM_PRESCALE_EN; otherwise the counter advances every clk.
module pwm_controller #(
    parameter int PRESCALE = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    input  logic        cfg_update,
    output logic        cfg_pending,
    output logic        period_start,
    output logic [15:0] pwm_out
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] en_out_sh_q, en_out_sh_d;
    logic [15:0] en_pwm_sh_q, en_pwm_sh_d;
    logic [7:0]  duty_sh_q, duty_sh_d;
    logic        period_start_q, period_start_d;
    logic [15:0] pwm_out_q, pwm_out_d;
    logic        tick;
    logic        boundary;
    logic        load;
    logic        pwm_high;

    if (PRESCALE < 0) begin : g_prescale_check
        $error("PRESCALE must be non-negative");
    end

`ifdef PWM_PRESCALE_EN
    localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE);

    logic [PW-1:0] presc_q, presc_d;

    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        boundary = tick && (cnt_q == 8'hFF);
        // A request arriving exactly at the wrap is honoured immediately.
        load     = boundary && ((state_q == ST_PENDING) || cfg_update);
        cnt_d    = tick ? cnt_q + 8'd1 : cnt_q;

        state_d = state_q;
        if (boundary) begin
            state_d = ST_IDLE;
        end else if (cfg_update) begin
            state_d = ST_PENDING;
        end

        en_out_sh_d = en_out_sh_q;
        en_pwm_sh_d = en_pwm_sh_q;
        duty_sh_d   = duty_sh_q;
        if (load) begin
            en_out_sh_d = {en_reg_out_15_8, en_reg_out_7_0};
            en_pwm_sh_d = {en_reg_pwm_15_8, en_reg_pwm_7_0};
            duty_sh_d   = pwm_duty_cycle;
        end

        // Duty 255 means fully on, not 255/256.
        pwm_high       = (duty_sh_q == 8'hFF) || (cnt_q < duty_sh_q);
        pwm_out_d      = en_out_sh_q & (~en_pwm_sh_q | {16{pwm_high}});
        period_start_d = boundary;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            en_out_sh_q    <= '0;
            en_pwm_sh_q    <= '0;
            duty_sh_q      <= '0;
            period_start_q <= 1'b0;
            pwm_out_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            en_out_sh_q    <= en_out_sh_d;
            en_pwm_sh_q    <= en_pwm_sh_d;
            duty_sh_q      <= duty_sh_d;
            period_start_q <= period_start_d;
            pwm_out_q      <= pwm_out_d;
        end
    end

    assign cfg_pending  = (state_q == ST_PENDING);
    assign period_start = period_start_q;
    assign pwm_out      = pwm_out_q;

endmodule

// File: tb/tb_pwm_controller.sv
// Self-checking bench for pwm_controller: a cycle-indexed reference model predicts every output.
// Works with or without PWM_PRESCALE_EN defined.
module tb_pwm_controller;

    localparam int PRESCALE = 3;
`ifdef PWM_PRESCALE_EN
    localparam int P = PRESCALE + 1;
`else
    localparam int P = 1;
`endif
    localparam int PER = 256 * P;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
    logic        cfg_update;
    logic        cfg_pending;
    logic        period_start;
    logic [15:0] pwm_out;

    int n_checks = 0;
    int n_errors = 0;
    int k = 0;

    logic [15:0] m_en_out, m_en_pwm;
    logic [7:0]  m_duty;
    bit          m_pend;

    pwm_controller #(.PRESCALE(PRESCALE)) dut (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (eo_lo),
        .en_reg_out_15_8 (eo_hi),
        .en_reg_pwm_7_0  (ep_lo),
        .en_reg_pwm_15_8 (ep_hi),
        .pwm_duty_cycle  (duty),
        .cfg_update      (cfg_update),
        .cfg_pending     (cfg_pending),
        .period_start    (period_start),
        .pwm_out         (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
        end
    endtask

    function automatic logic [15:0] model_pwm(input int cnt);
        logic [15:0] r;
        bit high;
        high = (m_duty == 8'hFF) || (cnt < int'(m_duty));
        for (int i = 0; i < 16; i++) begin
            if (!m_en_out[i])      r[i] = 1'b0;
            else if (!m_en_pwm[i]) r[i] = 1'b1;
            else                   r[i] = high;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_en_out = '0;
        m_en_pwm = '0;
        m_duty   = '0;
        m_pend   = 1'b0;
    endtask

    // One clk: predict from cycle index k, advance, compare all outputs.
    task automatic step();
        int          phase, cnt;
        bit          bnd;
        logic [15:0] exp_out;
        phase   = k % PER;
        cnt     = phase / P;
        bnd     = (phase == PER - 1);
        exp_out = model_pwm(cnt);
        if (bnd && (m_pend || cfg_update)) begin
            m_en_out = {eo_hi, eo_lo};
            m_en_pwm = {ep_hi, ep_lo};
            m_duty   = duty;
            m_pend   = 1'b0;
        end else if (cfg_update) begin
            m_pend = 1'b1;
        end
        @(posedge clk);
        #1;
        k++;
        check("pwm_out", 32'(pwm_out), 32'(exp_out));
        check("period_start", 32'(period_start), 32'(bnd));
        check("cfg_pending", 32'(cfg_pending), 32'(m_pend));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to_phase(input int ph);
        for (int i = 0; i < PER && (k % PER) != ph; i++) step();
    endtask

    task automatic pulse_update();
        cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
    endtask

    task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        eo_lo = eo[7:0];
        eo_hi = eo[15:8];
        ep_lo = ep[7:0];
        ep_hi = ep[15:8];
        duty  = d;
    endtask

    // Align to a period_start, then measure period length and channel-0 high time.
    task automatic measure(input string tag, input int exp_hi);
        bit seen;
        int hi, len;
        seen = 1'b0;
        for (int i = 0; i < PER + 2 && !seen; i++) begin
            step();
            seen = period_start;
        end
        check({tag, "_ps_found"}, 32'(seen), 32'd1);
        hi  = pwm_out[0] ? 1 : 0;
        len = 0;
        do begin
            step();
            len++;
            if (!period_start && pwm_out[0]) hi++;
        end while (!period_start && len < 2 * PER);
        check({tag, "_period_len"}, 32'(len), 32'(PER));
        check({tag, "_high_clks"}, 32'(hi), 32'(exp_hi));
    endtask

    initial begin
        cfg_update = 1'b0;
        set_cfg('0, '0, '0);
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_pwm_out", 32'(pwm_out), 32'd0);
        check("rst_cfg_pending", 32'(cfg_pending), 32'd0);
        check("rst_period_start", 32'(period_start), 32'd0);
        rst = 1'b0;
        k   = 0;

        // Static-on: channel 0 enabled without PWM mode.
        set_cfg(16'h0001, 16'h0000, 8'($urandom_range(255)));
        run(5);
        pulse_update();
        check("static_pending", 32'(cfg_pending), 32'd1);
        run_to_phase(PER - 1);
        step();
        run(PER);
        check("static_on", 32'(pwm_out), 32'h0001);

        // 50% duty on all channels.
        set_cfg(16'hFFFF, 16'hFFFF, 8'h80);
        pulse_update();
        run_to_phase(PER - 1);
        step();
        measure("duty50", 128 * P);

        // Duty extremes.
        set_cfg(16'hFFFF, 16'hFFFF, 8'h00);
        pulse_update();
        run_to_phase(PER - 1);
        step();
        measure("duty00", 0);
        set_cfg(16'hFFFF, 16'hFFFF, 8'hFF);
        pulse_update();
        run_to_phase(PER - 1);
        step();
        measure("dutyFF", PER);
        check("dutyFF_out", 32'(pwm_out), 32'hFFFF);

        // Deferred update requested mid-period.
        set_cfg(16'hFFFF, 16'hFFFF, 8'h40);
        pulse_update();
        run_to_phase(PER - 1);
        step();
        run_to_phase(10 * P);
        duty = 8'hC0;
        pulse_update();
        run(3);
        pulse_update();
        check("deferred_pending", 32'(cfg_pending), 32'd1);
        measure("deferred", 192 * P);

        // cfg_update exactly at the wrap, from IDLE and from PENDING.
        set_cfg(16'($urandom), 16'($urandom), 8'($urandom_range(255)));
        run_to_phase(PER - 1);
        pulse_update();
        check("coinc_idle_pending", 32'(cfg_pending), 32'd0);
        run(PER / 2);
        pulse_update();
        run(5);
        set_cfg(16'($urandom), 16'($urandom), 8'($urandom_range(255)));
        run_to_phase(PER - 1);
        pulse_update();
        check("coinc_pend_pending", 32'(cfg_pending), 32'd0);
        run(PER / 2);

        // Random configurations and request timing.
        for (int r = 0; r < 6; r++) begin
            set_cfg(16'($urandom), 16'($urandom), 8'($urandom_range(255)));
            for (int i = 0; i < PER + PER / 2; i++) begin
                if ($urandom_range(31) == 0)
                    set_cfg(16'($urandom), 16'($urandom), 8'($urandom_range(255)));
                cfg_update = ($urandom_range(63) == 0);
                step();
            end
            cfg_update = 1'b0;
        end

        // Reset mid-run with all outputs high and an update pending.
        set_cfg(16'hFFFF, 16'h0000, 8'($urandom_range(255)));
        pulse_update();
        run_to_phase(PER - 1);
        step();
        run(20);
        check("pre_rst_out", 32'(pwm_out), 32'hFFFF);
        set_cfg(16'hFFFF, 16'h0000, 8'h10);
        pulse_update();
        check("pre_rst_pending", 32'(cfg_pending), 32'd1);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_out", 32'(pwm_out), 32'd0);
        check("async_rst_pending", 32'(cfg_pending), 32'd0);
        check("async_rst_ps", 32'(period_start), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("hold_rst_out", 32'(pwm_out), 32'd0);
            check("hold_rst_pending", 32'(cfg_pending), 32'd0);
            check("hold_rst_ps", 32'(period_start), 32'd0);
        end
        rst = 1'b0;
        k   = 0;
        run(PER + 20);
        check("post_rst_no_load", 32'(pwm_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
